// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and constants
//
// Purpose : constants, opcode encodings and fetch types shared by the
//           fetch front end and the pipelined core.
// Contents: NOP_WORD, OPC_* opcode encodings, fetch_state_t, fetch_entry_t.
package riscv_pkg;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_S      = 7'b0100011;
    localparam logic [6:0] OPC_B      = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// rtl/riscv_fetch_unit_fifo.sv - prefetch FIFO of {pc, instr} entries
//
// Purpose : small circular buffer between the memory response channel and
//           the core. Synchronous flush has priority over push/pop.
// Ports   : clk, rst (async active-low), push/push_data, pop, flush,
//           head (entry at read pointer), empty, full, count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so full+pop+push is accepted.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage needs no reset: empty gates every read of it.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch front end for the pipelined core
//
// Purpose : owns the fetch PC, issues sequential word reads to instruction
//           memory, buffers responses in a prefetch FIFO and presents them
//           to the core; redirects flush the FIFO and drop stale responses.
// Ports   : clk, rst (async active-low)
//           en                         - fetch enable
//           imem_req_valid/ready/addr  - request channel
//           imem_rsp_valid/data        - in-order response channel
//           redirect_valid/pc          - core branch/jump redirect
//           instr_ready                - core consumes the head entry
//           instruction/instr_pc/instr_valid - FIFO head (NOP/0 when empty)
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_WORD   = riscv_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   w_redirect_target;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] w_outstanding_nxt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_drop_cnt_nxt;
    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_credits_used;
    logic          w_hs;
    logic          w_rsp_acc;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Every FIFO slot plus every in-flight request consumes one credit, so
    // a response always has room to land.
    assign w_credits_used = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign imem_req_valid = (r_state == ST_FETCH) && en
                         && (w_credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_fetch_pc;

    assign w_hs       = imem_req_valid && imem_req_ready;
    assign w_rsp_acc  = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop = w_rsp_acc && (r_drop_cnt != '0);
    assign w_push     = w_rsp_acc && !w_rsp_drop && (r_state == ST_FETCH)
                     && !redirect_valid;
    assign w_pop      = instr_valid && instr_ready && !redirect_valid;

    assign w_outstanding_nxt = r_outstanding + CW'(w_hs) - CW'(w_rsp_acc);

    // On redirect everything still in flight after this cycle is stale,
    // including a request handshaking right now.
    always_comb begin
        w_drop_cnt_nxt = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_cnt_nxt = w_outstanding_nxt;
        end else if (w_rsp_drop) begin
            w_drop_cnt_nxt = r_drop_cnt - CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!en && (r_outstanding == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_drop_cnt_nxt == '0) begin
                    w_state_nxt = en ? ST_FETCH : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (redirect_valid) begin
            w_state_nxt = (w_drop_cnt_nxt != '0) ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= PC_RESET;
            r_rsp_pc      <= PC_RESET;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
                r_rsp_pc   <= w_redirect_target;
            end else begin
                if (w_hs) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
            end
        end
    end

    assign w_push_entry.pc    = r_rsp_pc;
    assign w_push_entry.instr = imem_rsp_data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .count     (w_fifo_count)
    );

    assign instr_valid = !w_fifo_empty;
    assign instruction = w_fifo_empty ? NOP_WORD : w_head.instr;
    assign instr_pc    = w_fifo_empty ? 32'h0 : w_head.pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - scoreboard bench for riscv_fetch_unit
module tb_riscv_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .PC_RESET   (32'h0000_0000),
        .FIFO_DEPTH (4),
        .NOP_WORD   (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid)
    );

    typedef struct {
        logic [31:0] addr;
        int          t;
    } mem_req_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs, applied by cycle() at the falling edge.
    int          p_ready = 100;
    int          p_iready = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          p_redir = 0;
    int          redir_mode = 0;   // 0 none, 1 this cycle, 2 random, 3 on addr match
    logic [31:0] redir_target = '0;
    logic [31:0] redir_match = '0;
    logic        cfg_en = 1'b0;
    logic        rel_rst = 1'b0;

    // Reference model: memory returns mem_word(addr) in order; the core
    // must see pc = target, target+4, ... for every request accepted since
    // the last redirect, each with its memory word.
    mem_req_t    mem_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] model_pc = '0;
    int          cyc = 0;
    int          last_t = 0;

    int          hs_cnt = 0;
    logic [31:0] last_hs_addr = '0;
    logic [31:0] prev_hs_addr = '0;
    logic        redir_fired = 1'b0;
    logic        redir_hs_rsp = 1'b0;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        track_bubbles = 1'b0;
    logic        seen_first = 1'b0;
    int          bubbles = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        mem_req_t e;
        logic     hs;
        @(negedge clk);
        if (rel_rst) begin
            rst     = 1'b1;
            rel_rst = 1'b0;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].t <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        en             = cfg_en;
        imem_req_ready = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_iready);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (redir_mode)
            1: begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_target;
            end
            2: begin
                if ($urandom_range(99) < p_redir) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = $urandom & 32'h0000_0FFF;
                end
            end
            3: begin
                if (imem_req_valid && imem_req_addr == redir_match) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = redir_target;
                    redir_mode     = 0;
                end
            end
            default: ;
        endcase
        #1;
        if (rst) begin
            if (prev_pending && en) begin
                chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
                chk("req_hold_addr", imem_req_addr, prev_addr);
            end
            hs = imem_req_valid && imem_req_ready;
            if (hs) begin
                hs_cnt++;
                prev_hs_addr = last_hs_addr;
                last_hs_addr = imem_req_addr;
                e.addr = imem_req_addr;
                e.t    = cyc + $urandom_range(lat_max, lat_min);
                if (e.t <= last_t) e.t = last_t + 1;
                last_t = e.t;
                mem_q.push_back(e);
            end
            if (redirect_valid) begin
                redir_fired  = 1'b1;
                redir_hs_rsp = hs && imem_rsp_valid;
                exp_pc_q.delete();
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (hs) begin
                chk("req_addr", imem_req_addr, model_pc);
                exp_pc_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            prev_pending = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr    = imem_req_addr;
        end
        cyc++;
    endtask

    task automatic clear_model();
        mem_q.delete();
        exp_pc_q.delete();
        model_pc     = 32'h0;
        prev_pending = 1'b0;
    endtask

    // Monitor: compares the presented head against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b1 && !redirect_valid) begin
            if (instr_valid) begin
                seen_first = 1'b1;
                if (exp_pc_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h, required no instruction", instr_pc);
                end else begin
                    chk("instr_pc", instr_pc, exp_pc_q[0]);
                    chk("instruction", instruction, mem_word(exp_pc_q[0]));
                    if (instr_ready) void'(exp_pc_q.pop_front());
                end
            end else begin
                chk("nop_word", instruction, NOP);
                chk("nop_pc", instr_pc, 32'h0);
                if (track_bubbles && seen_first) bubbles++;
            end
        end
    end

    initial begin
        int ok;
        int h0;
        rst = 1'b0; en = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        repeat (2) cycle();

        // Fill to the credit limit with the core stalled.
        cfg_en = 1'b1; p_ready = 100; p_iready = 0; lat_min = 1; lat_max = 1;
        rel_rst = 1'b1;
        repeat (12) cycle();
        chk("credit_hs_count", 32'(hs_cnt), 32'd4);
        chk("credit_last_addr", last_hs_addr, 32'h0000_000C);
        chk("credit_req_valid", 32'(imem_req_valid), 32'd0);
        chk("first_instr_valid", 32'(instr_valid), 32'd1);
        chk("first_instr_pc", instr_pc, 32'h0);
        chk("first_instruction", instruction, mem_word(32'h0));

        // Steady streaming: one instruction per cycle, no bubbles.
        p_iready = 100; track_bubbles = 1'b1; seen_first = 1'b0; bubbles = 0;
        repeat (40) cycle();
        track_bubbles = 1'b0;
        chk("stream_bubbles", 32'(bubbles), 32'd0);

        // Request held while memory stalls.
        redir_mode = 1; redir_target = 32'h10; p_ready = 0;
        cycle();
        redir_mode = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (imem_req_valid) begin ok = 1; break; end
        end
        chk("stall_reach_valid", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_req_addr, 32'h10);
            cycle();
        end
        p_ready = 100;
        cycle();
        chk("stall_hs_addr", last_hs_addr, 32'h10);
        cycle();
        chk("stall_next_addr", last_hs_addr, 32'h14);

        // Redirect with three requests in flight (3-cycle memory).
        redir_mode = 1; redir_target = 32'h40; lat_min = 3; lat_max = 3;
        cycle();
        redir_mode = 0;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (mem_q.size() == 3) begin ok = 1; break; end
        end
        chk("three_outstanding", 32'(ok), 32'd1);
        redir_mode = 1; redir_target = 32'h100; p_ready = 0;
        cycle();
        redir_mode = 0; p_ready = 100;
        cycle();
        chk("redir_flush_valid", 32'(instr_valid), 32'd0);
        chk("redir_flush_nop", instruction, NOP);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (instr_valid) begin ok = 1; break; end
        end
        chk("redir_deliver", 32'(ok), 32'd1);
        chk("redir_first_pc", instr_pc, 32'h100);

        // Redirect coinciding with a handshake (0x20) and a response.
        lat_min = 1; lat_max = 1;
        redir_mode = 1; redir_target = 32'h0;
        cycle();
        redir_fired = 1'b0; redir_hs_rsp = 1'b0;
        redir_mode = 3; redir_match = 32'h20; redir_target = 32'h203;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (redir_fired) break;
        end
        redir_mode = 0;
        chk("redir_same_cycle", 32'(redir_hs_rsp), 32'd1);
        h0 = hs_cnt; ok = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (hs_cnt != h0) begin ok = 1; break; end
        end
        chk("redir_align_seen", 32'(ok), 32'd1);
        chk("redir_align_addr", last_hs_addr, 32'h200);

        // PC wrap, then asynchronous reset mid-burst.
        redir_mode = 1; redir_target = 32'hFFFF_FFF8;
        cycle();
        redir_mode = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            h0 = hs_cnt;
            cycle();
            if (hs_cnt != h0 && last_hs_addr == 32'h0) begin ok = 1; break; end
        end
        chk("wrap_seen", 32'(ok), 32'd1);
        chk("wrap_prev_addr", prev_hs_addr, 32'hFFFF_FFFC);
        repeat (2) cycle();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_instr_valid", 32'(instr_valid), 32'd0);
        chk("async_instruction", instruction, NOP);
        chk("async_instr_pc", instr_pc, 32'h0);
        clear_model();
        repeat (2) cycle();
        clear_model();
        rel_rst = 1'b1;

        // Randomised traffic against the scoreboard.
        redir_mode = 2;
        for (int seg = 0; seg < 30; seg++) begin
            p_ready  = $urandom_range(100, 20);
            p_iready = $urandom_range(100, 10);
            lat_min  = 1;
            lat_max  = $urandom_range(4, 1);
            p_redir  = $urandom_range(5, 0);
            cfg_en   = ($urandom_range(4) != 0);
            repeat (100) cycle();
        end
        redir_mode = 0; cfg_en = 1'b1; p_iready = 100; p_ready = 100;
        repeat (30) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
